// File: rtl/piezo_sched_pkg.sv
// Shared constants for the piezo burst scheduler: FSM state codes, register map, CTRL/IRQ bit positions.
package piezo_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_SELECT = 3'd2;
  localparam logic [2:0] ST_BURST  = 3'd3;
  localparam logic [2:0] ST_GUARD  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_MASK_LO = 3'd2;
  localparam logic [2:0] ADDR_MASK_HI = 3'd3;
  localparam logic [2:0] ADDR_BURST   = 3'd4;
  localparam logic [2:0] ADDR_GUARD   = 3'd5;
  localparam logic [2:0] ADDR_CUR_CH  = 3'd6;
  localparam logic [2:0] ADDR_IRQ     = 3'd7;

  localparam int CTRL_START = 0;
  localparam int CTRL_ARM   = 1;
  localparam int CTRL_CONT  = 2;
  localparam int CTRL_ABORT = 3;

  localparam int IRQ_DONE  = 0;
  localparam int IRQ_FAULT = 1;

endpackage

// File: rtl/piezo_next_ch_finder.sv
// Masked priority encoder: lowest set mask bit at or above start_idx, plus lowest set bit overall.
// Purely combinational; start_idx may exceed NUM_CH-1, in which case only the wrap result is valid.
module piezo_next_ch_finder #(
  parameter int NUM_CH = 61
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [6:0]        start_idx,
  output logic              found,
  output logic [5:0]        idx,
  output logic [5:0]        wrap_idx,
  output logic              any
);

  // Scanning downwards lets the last hit be the lowest qualifying bit.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    wrap_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        wrap_idx = 6'(i);
        if (7'(i) >= start_idx) begin
          found = 1'b1;
          idx   = 6'(i);
        end
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/piezo_burst_scheduler.sv
// Time-division piezo burst scheduler: fires masked channels one at a time (burst, guard, 1-cycle select gap).
// Avalon-MM register file with 1-cycle read latency; interlock drop or abort forces outputs off on the next edge.
module piezo_burst_scheduler
  import piezo_sched_pkg::*;
#(
  parameter int          NUM_CH    = 61,
  parameter int          CNT_W     = 24,
  parameter int unsigned DEF_BURST = 1000,
  parameter int unsigned DEF_GUARD = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              event_trigger,
  input  logic              piezo_enable_in,
  output logic [NUM_CH-1:0] piezo_out,
  output logic              piezo_enable,
  output logic [2:0]        piezo_status,
  output logic              fire_strobe,
  output logic [5:0]        fire_channel,
  output logic              irq
);

  logic [2:0]        state;
  logic              ctrl_arm, ctrl_cont;
  logic [31:0]       mask_lo;
  logic [NUM_CH-33:0] mask_hi;
  logic [CNT_W-1:0]  burst_len, guard_len;
  logic [NUM_CH-1:0] w_mask;
  logic [CNT_W-1:0]  w_burst, w_guard, cnt;
  logic [5:0]        cur_ch;
  logic [6:0]        next_idx;
  logic [7:0]        round_cnt;
  logic [1:0]        irq_src;
  logic [2:0]        trig_sync;
  logic              trig_rise;
  logic              wr_ctrl, start, abort, trip;
  logic              found, any;
  logic [5:0]        idx, wrap_idx;

  piezo_next_ch_finder #(.NUM_CH(NUM_CH)) u_finder (
    .mask     (w_mask),
    .start_idx(next_idx),
    .found    (found),
    .idx      (idx),
    .wrap_idx (wrap_idx),
    .any      (any)
  );

  assign trig_rise = trig_sync[1] & ~trig_sync[2];
  assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
  assign start     = wr_ctrl && avs_writedata[CTRL_START];
  assign abort     = wr_ctrl && avs_writedata[CTRL_ABORT];
  assign trip      = !piezo_enable_in &&
                     (state == ST_ARMED || state == ST_SELECT || state == ST_BURST || state == ST_GUARD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ctrl_arm     <= 1'b0;
      ctrl_cont    <= 1'b0;
      mask_lo      <= '0;
      mask_hi      <= '0;
      burst_len    <= CNT_W'(DEF_BURST);
      guard_len    <= CNT_W'(DEF_GUARD);
      w_mask       <= '0;
      w_burst      <= '0;
      w_guard      <= '0;
      cnt          <= '0;
      cur_ch       <= '0;
      next_idx     <= '0;
      round_cnt    <= '0;
      irq_src      <= '0;
      trig_sync    <= '0;
      fire_strobe  <= 1'b0;
      fire_channel <= '0;
    end else begin
      fire_strobe <= 1'b0;
      trig_sync   <= {trig_sync[1:0], event_trigger};

      if (avs_write) begin
        case (avs_address)
          ADDR_CTRL: begin
            ctrl_arm  <= avs_writedata[CTRL_ARM];
            ctrl_cont <= avs_writedata[CTRL_CONT];
          end
          ADDR_MASK_LO: mask_lo   <= avs_writedata;
          ADDR_MASK_HI: mask_hi   <= avs_writedata[NUM_CH-33:0];
          ADDR_BURST:   burst_len <= avs_writedata[CNT_W-1:0];
          ADDR_GUARD:   guard_len <= avs_writedata[CNT_W-1:0];
          ADDR_IRQ:     irq_src   <= irq_src & ~avs_writedata[1:0];
          default: ;
        endcase
      end

      // Later irq_src bit sets below override a same-cycle W1C clear.
      if (abort) begin
        state <= ST_IDLE;
      end else if (trip) begin
        state              <= ST_FAULT;
        irq_src[IRQ_FAULT] <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            w_mask   <= {mask_hi, mask_lo};
            w_burst  <= burst_len;
            w_guard  <= guard_len;
            next_idx <= '0;
            state    <= avs_writedata[CTRL_ARM] ? ST_ARMED : ST_SELECT;
          end
          ST_ARMED: if (trig_rise) state <= ST_SELECT;
          ST_SELECT: begin
            if (found || (ctrl_cont && any)) begin
              state        <= ST_BURST;
              cur_ch       <= found ? idx : wrap_idx;
              fire_channel <= found ? idx : wrap_idx;
              fire_strobe  <= 1'b1;
              cnt          <= (w_burst == '0) ? '0 : w_burst - 1'b1;
              if (!found) round_cnt <= round_cnt + 8'd1;
            end else begin
              state             <= ST_DONE;
              irq_src[IRQ_DONE] <= 1'b1;
            end
          end
          ST_BURST: begin
            if (cnt == '0) begin
              next_idx <= {1'b0, cur_ch} + 7'd1;
              if (w_guard == '0) begin
                state <= ST_SELECT;
              end else begin
                state <= ST_GUARD;
                cnt   <= w_guard - 1'b1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_GUARD: begin
            if (cnt == '0) state <= ST_SELECT;
            else           cnt   <= cnt - 1'b1;
          end
          ST_DONE:  state <= ST_IDLE;
          ST_FAULT: if (start) state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        ADDR_CTRL:    avs_readdata <= {29'd0, ctrl_cont, ctrl_arm, 1'b0};
        ADDR_STATUS:  avs_readdata <= {8'd0, round_cnt, 6'd0, irq_src, 5'd0, state};
        ADDR_MASK_LO: avs_readdata <= mask_lo;
        ADDR_MASK_HI: avs_readdata <= 32'(mask_hi);
        ADDR_BURST:   avs_readdata <= 32'(burst_len);
        ADDR_GUARD:   avs_readdata <= 32'(guard_len);
        ADDR_CUR_CH:  avs_readdata <= 32'(cur_ch);
        default:      avs_readdata <= 32'(irq_src);
      endcase
    end
  end

  assign piezo_enable = (state == ST_BURST);
  assign piezo_out    = piezo_enable ? (NUM_CH'(1) << cur_ch) : '0;
  assign piezo_status = state;
  assign irq          = |irq_src;

endmodule

// File: tb/tb_piezo_burst_scheduler.sv
// Self-checking bench: register table, sequence-level firing model for randomized runs, hand-written corner cases.
module tb_piezo_burst_scheduler;

  localparam int NUM_CH = 61;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        avs_address;
  logic              avs_write, avs_read;
  logic [31:0]       avs_writedata, avs_readdata;
  logic              event_trigger, piezo_enable_in;
  logic [NUM_CH-1:0] piezo_out;
  logic              piezo_enable, fire_strobe, irq;
  logic [2:0]        piezo_status;
  logic [5:0]        fire_channel;

  always #5 clk = ~clk;

  piezo_burst_scheduler #(.NUM_CH(NUM_CH), .CNT_W(24), .DEF_BURST(1000), .DEF_GUARD(5000)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .event_trigger(event_trigger), .piezo_enable_in(piezo_enable_in), .piezo_out(piezo_out),
    .piezo_enable(piezo_enable), .piezo_status(piezo_status), .fire_strobe(fire_strobe),
    .fire_channel(fire_channel), .irq(irq)
  );

  typedef struct packed {
    logic [2:0]        st;
    logic              strobe;
    logic              en;
    logic [NUM_CH-1:0] out;
  } smp_t;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  int   checks = 0;
  int   failures = 0;
  int   strobe_cnt = 0;
  bit   rec = 0;
  smp_t trace[$];
  int   ch_trace[$];

  always @(negedge clk) begin
    if (fire_strobe) strobe_cnt++;
    if (rec) begin
      trace.push_back('{st: piezo_status, strobe: fire_strobe, en: piezo_enable, out: piezo_out});
      ch_trace.push_back(int'(fire_channel));
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_cfg(input logic [NUM_CH-1:0] m, input int b, input int g);
    wr(3'd2, m[31:0]);
    wr(3'd3, 32'(m[NUM_CH-1:32]));
    wr(3'd4, b);
    wr(3'd5, g);
  endtask

  task automatic wait_strobe(input string name, input int budget, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < budget) begin
      @(posedge clk); #1; n++;
      if (fire_strobe) seen = 1;
    end
    chk({name, " strobe_seen"}, seen, 1);
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (piezo_status == s) seen = 1;
    end
    chk({name, " state_reached"}, seen, 1);
  endtask

  task automatic start_trace(input logic [31:0] ctrl);
    trace.delete(); ch_trace.delete();
    wr(3'd0, ctrl | 32'h1);
    rec = 1;
  endtask

  task automatic end_trace(input string name);
    bit fin = 0;
    smp_t last;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(posedge clk); #2;
      if (trace.size() > 0) begin
        last = trace[trace.size() - 1];
        if (last.st == 3'd0) fin = 1;
      end
    end
    rec = 0;
    chk({name, " run_finished"}, fin, 1);
  endtask

  // Expected per-cycle schedule from the cycle after the start write: for each enabled channel
  // ascending, one select cycle, max(burst,1) drive cycles, guard idle cycles; then select, done, idle.
  task automatic check_trace(input string name, input logic [NUM_CH-1:0] m, input int b, input int g);
    smp_t e[$];
    int   ech[$];
    smp_t z;
    int   nb;
    bit   bad = 0;
    nb = (b < 1) ? 1 : b;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m[ch]) begin
        z = '{st: 3'd2, strobe: 1'b0, en: 1'b0, out: '0};
        e.push_back(z); ech.push_back(0);
        for (int k = 0; k < nb; k++) begin
          z = '{st: 3'd3, strobe: (k == 0), en: 1'b1, out: '0};
          z.out[ch] = 1'b1;
          e.push_back(z); ech.push_back(ch);
        end
        for (int k = 0; k < g; k++) begin
          z = '{st: 3'd4, strobe: 1'b0, en: 1'b0, out: '0};
          e.push_back(z); ech.push_back(0);
        end
      end
    end
    z = '{st: 3'd2, strobe: 1'b0, en: 1'b0, out: '0}; e.push_back(z); ech.push_back(0);
    z.st = 3'd5; e.push_back(z); ech.push_back(0);
    z.st = 3'd0; e.push_back(z); ech.push_back(0);
    chk({name, " trace_len"}, trace.size(), e.size());
    for (int i = 0; i < e.size() && i < trace.size() && !bad; i++) begin
      checks++;
      if (trace[i] !== e[i]) begin
        failures++;
        bad = 1;
        $display("FAIL %s cycle %0d actual st=%0d strobe=%0b en=%0b out=%0h expected st=%0d strobe=%0b en=%0b out=%0h",
                 name, i, trace[i].st, trace[i].strobe, trace[i].en, trace[i].out,
                 e[i].st, e[i].strobe, e[i].en, e[i].out);
      end else if (e[i].strobe) begin
        chk({name, " fire_channel"}, ch_trace[i], ech[i]);
      end
    end
  endtask

  initial begin
    reg_vec_t          vecs[$];
    logic [31:0]       d;
    logic [NUM_CH-1:0] m;
    int                n, s0, last, cycle, b, g;

    reset = 1'b1; avs_address = '0; avs_write = 0; avs_read = 0; avs_writedata = '0;
    event_trigger = 0; piezo_enable_in = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset piezo_out", piezo_out, 0);
    chk("reset piezo_enable", piezo_enable, 0);
    chk("reset status", piezo_status, 0);
    chk("reset fire", {fire_strobe, fire_channel}, 0);
    chk("reset irq", irq, 0);

    vecs = '{
      '{0, 3'd0, 32'h0, 32'h0},          '{0, 3'd1, 32'h0, 32'h0},
      '{0, 3'd2, 32'h0, 32'h0},          '{0, 3'd3, 32'h0, 32'h0},
      '{0, 3'd4, 32'h0, 32'd1000},       '{0, 3'd5, 32'h0, 32'd5000},
      '{0, 3'd6, 32'h0, 32'h0},          '{0, 3'd7, 32'h0, 32'h0},
      '{1, 3'd2, 32'hDEADBEEF, 32'hDEADBEEF},
      '{1, 3'd3, 32'hFFFFFFFF, 32'h1FFFFFFF},
      '{1, 3'd4, 32'hFFFFFFFF, 32'h00FFFFFF},
      '{1, 3'd5, 32'h00012345, 32'h00012345},
      '{1, 3'd7, 32'h00000003, 32'h0},
      '{1, 3'd1, 32'hFFFFFFFF, 32'h0}
    };
    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      chk($sformatf("reg vec %0d", i), d, vecs[i].exp);
    end

    // Two-channel run, then done irq and STATUS, then W1C
    set_cfg(61'h5, 4, 2);
    start_trace(0); end_trace("t1"); check_trace("t1", 61'h5, 4, 2);
    chk("t1 irq", irq, 1);
    rd(3'd1, d); chk("t1 status", d, 32'h100);
    rd(3'd6, d); chk("t1 cur_ch", d, 2);
    wr(3'd7, 32'h1); chk("t1 irq cleared", irq, 0);

    for (int r = 0; r < 8; r++) begin
      m = '0;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) m[$urandom_range(0, NUM_CH - 1)] = 1'b1;
      b = $urandom_range(0, 5);
      g = $urandom_range(0, 4);
      set_cfg(m, b, g);
      start_trace(0); end_trace("rand"); check_trace($sformatf("rand %0d", r), m, b, g);
    end

    // Length registers written mid-run only affect the next run; zero burst gives one cycle
    set_cfg(61'h3, 4, 3);
    start_trace(0); cyc(3); wr(3'd4, 10); end_trace("t6a"); check_trace("t6 running", 61'h3, 4, 3);
    start_trace(0); end_trace("t6b"); check_trace("t6 next run", 61'h3, 10, 3);
    wr(3'd4, 0);
    start_trace(0); end_trace("t6c"); check_trace("t6 zero burst", 61'h3, 0, 3);

    // Triggered start
    set_cfg(61'h30, 8, 1);
    wr(3'd0, 32'h3);
    chk("t2 armed", piezo_status, 1);
    cyc(3); chk("t2 armed holds", piezo_status, 1);
    s0 = strobe_cnt;
    event_trigger = 1;
    wait_strobe("t2", 20, n);
    chk("t2 trigger latency", n, 4);
    chk("t2 first channel", fire_channel, 4);
    event_trigger = 0; cyc(2); event_trigger = 1; cyc(3); event_trigger = 0;
    wait_state("t2 done", 3'd0, 100);
    cyc(10);
    chk("t2 no retrigger", piezo_status, 0);
    chk("t2 strobe count", strobe_cnt - s0, 2);

    // Interlock drop mid-burst
    wr(3'd7, 32'h3);
    set_cfg(61'h1, 10, 2);
    wr(3'd0, 32'h1);
    wait_strobe("t4", 20, n);
    cyc(2);
    piezo_enable_in = 0;
    @(posedge clk); #1;
    chk("t4 out off", piezo_out, 0);
    chk("t4 enable off", piezo_enable, 0);
    chk("t4 fault state", piezo_status, 6);
    chk("t4 irq", irq, 1);
    piezo_enable_in = 1;
    cyc(3); chk("t4 fault holds", piezo_status, 6);
    rd(3'd7, d); chk("t4 irq reg", d, 2);
    wr(3'd7, 32'h2); chk("t4 irq w1c", irq, 0);
    s0 = strobe_cnt;
    wr(3'd0, 32'h1); chk("t4 start exits fault", piezo_status, 0);
    cyc(5); chk("t4 stays idle", piezo_status, 0);
    chk("t4 no launch", strobe_cnt - s0, 0);

    // Abort in guard, then an empty-mask run
    set_cfg(61'h3, 2, 10);
    wr(3'd0, 32'h1);
    wait_state("t5 guard", 3'd4, 50);
    wr(3'd0, 32'h8);
    chk("t5 abort idle", piezo_status, 0);
    chk("t5 abort out", piezo_out, 0);
    chk("t5 abort no irq", irq, 0);
    set_cfg('0, 4, 2);
    start_trace(0); end_trace("t5"); check_trace("t5 empty mask", '0, 4, 2);
    chk("t5 done irq", irq, 1);
    wr(3'd7, 32'h3);

    // Continuous single channel: period 2, round counter wraps 255 -> 0
    m = '0; m[60] = 1'b1;
    set_cfg(m, 1, 0);
    wr(3'd0, 32'h5);
    n = 0; last = 0; cycle = 0;
    while (n < 256 && cycle < 2000) begin
      @(posedge clk); #1; cycle++;
      if (fire_strobe) begin
        if (n == 0) chk("t3 first out", piezo_out, m);
        else if (piezo_out !== m || cycle - last != 2) chk($sformatf("t3 pulse %0d period", n), {piezo_out, 8'(cycle - last)}, {m, 8'd2});
        else checks++;
        last = cycle; n++;
      end
    end
    chk("t3 strobes", n, 256);
    wr(3'd0, 32'h8);
    rd(3'd1, d); chk("t3 round_cnt 255", d[23:16], 255);
    wr(3'd0, 32'h5);
    wait_strobe("t3 restart a", 10, n);
    wait_strobe("t3 restart b", 10, n);
    chk("t3 restart period", n, 2);
    wr(3'd0, 32'h8);
    rd(3'd1, d); chk("t3 round_cnt wrap", d[23:16], 0);
    chk("t3 no irq", irq, 0);

    // Reset in the middle of a burst
    set_cfg(61'h1, 20, 0);
    wr(3'd0, 32'h1);
    wait_strobe("rst", 20, n);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst out off", piezo_out, 0);
    chk("rst enable off", piezo_enable, 0);
    chk("rst state", piezo_status, 0);
    reset = 1'b0;
    rd(3'd4, d); chk("rst burst default", d, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
